// File: rtl/gb_cpu_schedule_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// gb_cpu_schedule_sequencer_pkg
//
// Shared types for the m-cycle schedule sequencer and its neighbours (decoder,
// datapath). Holds the per-m-cycle control word, the branch condition codes,
// the sequencer state type, the all-zero control word and the condition
// evaluation helper.
// ---------------------------------------------------------------------------
package gb_cpu_schedule_sequencer_pkg;

  // ALU operation selected for one m-cycle. ALU_NOP must stay at encoding 0
  // so that an all-zero control word is a harmless idle cycle.
  typedef enum logic [3:0] {
    ALU_NOP,
    ALU_ADD,
    ALU_ADC,
    ALU_SUB,
    ALU_SBC,
    ALU_AND,
    ALU_XOR,
    ALU_OR,
    ALU_CP,
    ALU_INC,
    ALU_DEC,
    ALU_RLC,
    ALU_RRC,
    ALU_BIT,
    ALU_SET,
    ALU_RES
  } alu_op_t;

  // Increment/decrement unit operation on the address bus value.
  typedef enum logic [1:0] {
    IDU_NOP,
    IDU_INC,
    IDU_DEC,
    IDU_PASS
  } idu_op_t;

  // Source of the address driven onto the external bus.
  typedef enum logic [1:0] {
    ADDR_PC,
    ADDR_SP,
    ADDR_HL,
    ADDR_WZ
  } addr_src_t;

  // Branch condition tested on slots flagged with cc_check.
  typedef enum logic [1:0] {
    COND_NZ,
    COND_Z,
    COND_NC,
    COND_C
  } condition_code_t;

  // One m-cycle worth of datapath control.
  typedef struct packed {
    alu_op_t     alu_op;
    logic [3:0]  alu_destination;
    logic [3:0]  alu_source;
    idu_op_t     idu_op;
    logic [3:0]  idu_destination;
    addr_src_t   addr_src;
    logic        regfile_wren;
    logic        mem_wren;
    logic        drive_data_bus;
    logic        ir_load;
    logic        cc_check;
  } control_signals_t;

  typedef enum logic {
    SEQ_IDLE,
    SEQ_RUN
  } seq_state_t;

  // Idle control word: every field zero (ALU_NOP, IDU_NOP, no writes).
  localparam control_signals_t CTRL_NOP = '0;

  // True when the branch condition holds for the given Z and C flags.
  function automatic logic evalCondition(input condition_code_t cond,
                                         input logic z,
                                         input logic c);
    logic result;
    case (cond)
      COND_NZ: result = ~z;
      COND_Z:  result = z;
      COND_NC: result = ~c;
      COND_C:  result = c;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/gb_cpu_schedule_sequencer.sv
// ---------------------------------------------------------------------------
// gb_cpu_schedule_sequencer
//
// Latches a decoded schedule of up to DEPTH control slots and plays it out one
// slot per m-cycle strobe as a registered control word. Handles conditional
// truncation (a failed condition check jumps straight to the final fetch
// slot), the 0xCB prefix hand-off between instructions, stall and flush.
//
// Ports:
//   clk, reset        core clock, asynchronous active-high reset
//   m_cycle_en        m-cycle strobe; state advances only when high
//   stall             hold everything (bus wait); beats advance and load
//   flush             return to idle on the next clk edge; beats everything
//   load              a new schedule is offered on sched_*
//   sched_controls    DEPTH control slots, slot 0 executes first
//   sched_m_cycles    instruction length in m-cycles (clamped to 1..DEPTH)
//   sched_condition   condition tested on slots with cc_check set
//   sched_cb_next     the next fetched opcode is CB-prefixed
//   flag_z, flag_c    current Z and C flags
//   ctrl_o            live control word (registered)
//   slot_idx          index of the slot on ctrl_o
//   ready             a load is accepted on this m-cycle
//   busy              a schedule is executing
//   cb_mode           the executing instruction is CB-prefixed
//   cc_taken          result of the most recent condition check
// ---------------------------------------------------------------------------
module gb_cpu_schedule_sequencer
  import gb_cpu_schedule_sequencer_pkg::*;
#(
  parameter int DEPTH = 6,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         m_cycle_en,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         load,
  input  control_signals_t [DEPTH-1:0] sched_controls,
  input  logic [CNT_W-1:0]             sched_m_cycles,
  input  condition_code_t              sched_condition,
  input  logic                         sched_cb_next,
  input  logic                         flag_z,
  input  logic                         flag_c,
  output control_signals_t             ctrl_o,
  output logic [CNT_W-1:0]             slot_idx,
  output logic                         ready,
  output logic                         busy,
  output logic                         cb_mode,
  output logic                         cc_taken
);

  // Latched copy of the schedule being executed. cb_next outlives the
  // schedule: it tells the following instruction it is CB-prefixed.
  typedef struct packed {
    control_signals_t [DEPTH-1:0] controls;
    logic [CNT_W-1:0]             len;
    condition_code_t              condition;
    logic                         cb_next;
  } schedule_t;

  seq_state_t       state, state_next;
  schedule_t        sched, sched_next;
  control_signals_t ctrl_next;
  logic [CNT_W-1:0] idx_next;
  logic             cb_mode_next;
  logic             cc_taken_next;

  logic [CNT_W-1:0] load_len;
  logic [CNT_W-1:0] last_idx;
  logic             on_last;
  logic             step;
  logic             load_ok;
  logic             cond_ok;
  logic             skip;
  logic [CNT_W-1:0] adv_idx;
  control_signals_t adv_ctrl;

  // Out-of-range lengths are clamped so the index can never walk past the
  // last real slot.
  always_comb begin
    load_len = sched_m_cycles;
    if (sched_m_cycles == '0) begin
      load_len = CNT_W'(1);
    end else if (sched_m_cycles > CNT_W'(DEPTH)) begin
      load_len = CNT_W'(DEPTH);
    end
  end

  // The final slot overlaps the fetch of the next opcode, which is why a new
  // schedule may be accepted there as well as from idle.
  assign last_idx = sched.len - CNT_W'(1);
  assign on_last  = (state == SEQ_RUN) && (slot_idx == last_idx);
  assign busy     = (state == SEQ_RUN);
  assign ready    = ~reset && ((state == SEQ_IDLE) || on_last);
  assign step     = m_cycle_en && ~stall && ~flush;
  assign load_ok  = load && ready && step;

  // ctrl_o is the slot being left, so its cc_check decides whether the
  // condition applies on this advance. A failed check skips to the fetch slot.
  assign cond_ok = evalCondition(sched.condition, flag_z, flag_c);
  assign skip    = ctrl_o.cc_check && ~cond_ok;
  assign adv_idx = skip ? last_idx : slot_idx + CNT_W'(1);

  always_comb begin
    adv_ctrl = CTRL_NOP;
    for (int i = 0; i < DEPTH; i++) begin
      if (adv_idx == CNT_W'(i)) begin
        adv_ctrl = sched.controls[i];
      end
    end
  end

  // Next-state logic. Priority: flush, then load, then advance; stall and a
  // missing strobe both fall through to hold.
  always_comb begin
    state_next    = state;
    sched_next    = sched;
    ctrl_next     = ctrl_o;
    idx_next      = slot_idx;
    cb_mode_next  = cb_mode;
    cc_taken_next = cc_taken;

    if (flush) begin
      state_next         = SEQ_IDLE;
      ctrl_next          = CTRL_NOP;
      idx_next           = '0;
      cb_mode_next       = 1'b0;
      sched_next.cb_next = 1'b0;
    end else if (load_ok) begin
      state_next           = SEQ_RUN;
      sched_next.controls  = sched_controls;
      sched_next.len       = load_len;
      sched_next.condition = sched_condition;
      sched_next.cb_next   = sched_cb_next;
      ctrl_next            = sched_controls[0];
      idx_next             = '0;
      cb_mode_next         = sched.cb_next;
      cc_taken_next        = 1'b0;
    end else if (step && (state == SEQ_RUN)) begin
      if (ctrl_o.cc_check) begin
        cc_taken_next = cond_ok;
      end
      if (on_last) begin
        state_next   = SEQ_IDLE;
        ctrl_next    = CTRL_NOP;
        idx_next     = '0;
        cb_mode_next = 1'b0;
      end else begin
        ctrl_next = adv_ctrl;
        idx_next  = adv_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SEQ_IDLE;
      sched    <= '0;
      ctrl_o   <= CTRL_NOP;
      slot_idx <= '0;
      cb_mode  <= 1'b0;
      cc_taken <= 1'b0;
    end else begin
      state    <= state_next;
      sched    <= sched_next;
      ctrl_o   <= ctrl_next;
      slot_idx <= idx_next;
      cb_mode  <= cb_mode_next;
      cc_taken <= cc_taken_next;
    end
  end

endmodule

// File: doc/gb_cpu_schedule_sequencer.md
Name: gb_cpu_schedule_sequencer

Overview:
Parametrised m-cycle sequencer that replaces fixed 6-slot schedule handling at top level. Latches a decoded schedule of up to DEPTH control_signals_t slots and presents one slot per m-cycle as the live control word. Performs condition-code truncation, tracks the 0xCB prefix, and supports flush and stall. It sits between the decoder (schedule source) and the datapath (regfile, ALU, IDU, bus mux).

Parameters:
DEPTH, 6, number of control slots per schedule (>=2)
CNT_W, $clog2(DEPTH+1), width of the m-cycle count and index fields

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
m_cycle_en  in  1  m-cycle strobe; state advances only when high
stall  in  1  hold the current slot (bus wait); has priority over advance
flush  in  1  abort the current schedule and return to IDLE (interrupt dispatch / halt)
load  in  1  new schedule valid
sched_controls  in  DEPTH x control_signals_t  slot array, slot 0 executes first
sched_m_cycles  in  CNT_W  instruction length in m-cycles
sched_condition  in  2  condition_code_t to test on cc_check slots
sched_cb_next  in  1  next fetched opcode is CB-prefixed
flag_z, flag_c  in  1 each  current Z and C flags
ctrl_o  out  control_signals_t  live control word
slot_idx  out  CNT_W  index of the slot on ctrl_o
ready  out  1  a load is accepted on this m-cycle
busy  out  1  a schedule is executing
cb_mode  out  1  the instruction being executed is CB-prefixed
cc_taken  out  1  result of the most recent condition check (sticky until next load)

Behaviour:
- Reset is asynchronous, active-high. All outputs reset to 0; ctrl_o resets to all-zero (ALU_NOP, IDU_NOP, no wren, drive_data_bus=0); state resets to IDLE.
- States: IDLE, RUN. RUN holds a latched copy of the controls, the length len, the condition, and cb_next.
- ready = (state==IDLE) | (state==RUN & slot_idx==len-1) — this is the final slot, which overlaps the fetch.
- Load: accepted when load & ready & m_cycle_en & !stall & !flush. On the next cycle: state=RUN, slot_idx=0, ctrl_o=slot 0, cb_mode=previous cb_next latch, cc_taken=0.
- A load while !ready is ignored; the current schedule is unaffected.
- Length rule: len = sched_m_cycles clamped to [1, DEPTH]. A value of 0 is treated as 1; values >DEPTH are treated as DEPTH.
- Advance: when m_cycle_en & !stall & !flush in RUN and slot_idx < len-1, slot_idx increments and ctrl_o updates on the same edge.
- Final slot without a load: return to IDLE with ctrl_o zeroed.
- Condition check: when the slot being left has cc_check=1, the condition is evaluated against flag_z and flag_c at the advance edge (NZ, Z, NC, C).
  - Taken: cc_taken=1 and execution proceeds normally.
  - Not taken: cc_taken=0 and slot_idx jumps directly to len-1 (the fetch slot).
  - If the check is already on slot len-1, there is no skip.
- cc_check on the final slot has no truncation effect; cc_taken is still updated.
- Stall: all state holds, including ctrl_o. A load is not accepted during stall.
- Flush: takes effect on the next clk edge regardless of m_cycle_en.
  - Sets state=IDLE, ctrl_o=0, slot_idx=0, cb_mode=0, and clears the cb_next latch.
  - Flush beats both load and stall when asserted together.
- Reset mid-schedule behaves as flush, applied asynchronously.
- ctrl_o is registered, so slot N appears exactly one m-cycle-strobe edge after slot N-1. There is no combinational path from sched_* to ctrl_o.

Decomposition:
- Package additions:
  - seq_state_t enum {SEQ_IDLE, SEQ_RUN}.
  - Function evalCondition(condition_code_t, logic z, logic c) returning logic.
  - Constant CTRL_NOP of type control_signals_t (all fields zero).
  - schedule_t is generalised with a DEPTH-sized controls array via a parametrised typedef in the module's user.
- No sub-module; condition evaluation is the package function.

Test Plan:
- Load a 4-cycle schedule (slot k has alu_destination=k) with m_cycle_en every 4 clks -> ctrl_o slots 0,1,2,3 on successive strobes; ready high only in slot 3; IDLE afterwards.
- JR NZ-style schedule: len=3, slot0 cc_check=1, cond=COND_NZ, flag_z=1 -> slot sequence 0→2, cc_taken=0. Repeat with flag_z=0 -> sequence 0→1→2, cc_taken=1.
- Back-to-back loads: assert load on the final slot with sched_cb_next=1, then a second load -> the second schedule starts on the next strobe with no IDLE gap, and cb_mode=1 during it.
- Stall held for 3 strobes on slot 1 of 3, with load asserted -> slot 1 persists, load is ignored, slot 2 follows after stall deasserts.
- Flush asserted on slot 2 of 5, together with load -> ctrl_o=0 and busy=0 next clk; the load is not accepted; cb_mode cleared.
- sched_m_cycles=0 and sched_m_cycles=7 with DEPTH=6 -> runs 1 slot and 6 slots respectively. Async reset mid-RUN -> outputs zero immediately, without waiting for a clk edge.
